// File: rtl/match_sequencer_if.sv
// Query, result and matcher-control signal bundle for match_sequencer.
// slave = the sequencer's view; master = the host/matcher environment's view.
interface match_sequencer_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  q_valid;
  logic                  q_ready;
  logic [ADDR_WIDTH-1:0] q_addr;

  logic                  r_valid;
  logic                  r_ready;
  logic                  r_found;
  logic                  r_timeout;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_cycles;

  logic                  m_cs;
  logic [ADDR_WIDTH-1:0] m_vocab_start_addr;
  logic [ADDR_WIDTH-1:0] m_vocab_end_addr;
  logic [ADDR_WIDTH-1:0] m_input_start_addr;
  logic                  m_found;
  logic                  m_done;

  modport slave (
    input  q_valid, q_addr, r_ready, m_found, m_done,
    output q_ready, r_valid, r_found, r_timeout, r_addr, r_cycles,
           m_cs, m_vocab_start_addr, m_vocab_end_addr, m_input_start_addr
  );

  modport master (
    output q_valid, q_addr, r_ready, m_found, m_done,
    input  q_ready, r_valid, r_found, r_timeout, r_addr, r_cycles,
           m_cs, m_vocab_start_addr, m_vocab_end_addr, m_input_start_addr
  );
endinterface

// File: rtl/match_sequencer.sv
// Query FIFO plus launch/collect FSM driving one matcher search per query.
// Optional search watchdog is enabled by defining MATCH_SEQ_TIMEOUT_EN.
//
// state     | meaning
// S_IDLE    | waiting for a queued query; pops and launches
// S_SEARCH  | m_cs high, counting cycles until m_done (or watchdog)
// S_RELEASE | m_cs low for one cycle so the matcher returns to idle
// S_RESP    | result presented until r_valid && r_ready
module match_sequencer #(
  parameter int ADDR_WIDTH     = 4,
  parameter int QDEPTH         = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cfg_vocab_start_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_vocab_end_addr,
  output logic                  busy,
  match_sequencer_if.slave      bus
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("match_sequencer: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEARCH  = 2'd1,
    S_RELEASE = 2'd2,
    S_RESP    = 2'd3
  } state_e;

  logic [ADDR_WIDTH-1:0] mem_q [QDEPTH];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  full;
  logic                  push;
  logic                  pop;

  state_e                state_q, state_d;
  logic [7:0]            cyc_q, cyc_d;
  logic [7:0]            cyc_inc;
  logic                  found_q, found_d;
  logic [7:0]            rcyc_q, rcyc_d;
  logic [ADDR_WIDTH-1:0] vs_q, vs_d;
  logic [ADDR_WIDTH-1:0] ve_q, ve_d;
  logic [ADDR_WIDTH-1:0] in_q, in_d;
`ifdef MATCH_SEQ_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);
  logic                  timeout_q, timeout_d;
`endif

  // q_ready depends only on the registered count, so a pop never admits a same-edge push
  assign full = (count_q == CW'(QDEPTH));
  assign push = bus.q_valid && !full;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= bus.q_addr;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    found_d = found_q;
    rcyc_d  = rcyc_q;
    vs_d    = vs_q;
    ve_d    = ve_q;
    in_d    = in_q;
    pop     = 1'b0;
`ifdef MATCH_SEQ_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    cyc_inc = (cyc_q == 8'hFF) ? cyc_q : cyc_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          in_d    = mem_q[rd_ptr_q];
          vs_d    = cfg_vocab_start_addr;
          ve_d    = cfg_vocab_end_addr;
          cyc_d   = '0;
          state_d = S_SEARCH;
        end
      end
      S_SEARCH: begin
        cyc_d = cyc_inc;
        if (bus.m_done) begin
          found_d = bus.m_found;
          rcyc_d  = cyc_inc;
          state_d = S_RELEASE;
`ifdef MATCH_SEQ_TIMEOUT_EN
          timeout_d = 1'b0;
        end else if (cyc_inc == TO_LIMIT) begin
          found_d   = 1'b0;
          rcyc_d    = cyc_inc;
          timeout_d = 1'b1;
          state_d   = S_RELEASE;
`endif
        end
      end
      S_RELEASE: state_d = S_RESP;
      S_RESP: begin
        if (bus.r_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      found_q <= 1'b0;
      rcyc_q  <= '0;
      vs_q    <= '0;
      ve_q    <= '0;
      in_q    <= '0;
`ifdef MATCH_SEQ_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      found_q <= found_d;
      rcyc_q  <= rcyc_d;
      vs_q    <= vs_d;
      ve_q    <= ve_d;
      in_q    <= in_d;
`ifdef MATCH_SEQ_TIMEOUT_EN
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.q_ready            = !full;
  assign bus.r_valid            = (state_q == S_RESP);
  assign bus.r_found            = found_q;
  assign bus.r_addr             = in_q;
  assign bus.r_cycles           = rcyc_q;
  assign bus.m_cs               = (state_q == S_SEARCH);
  assign bus.m_vocab_start_addr = vs_q;
  assign bus.m_vocab_end_addr   = ve_q;
  assign bus.m_input_start_addr = in_q;
`ifdef MATCH_SEQ_TIMEOUT_EN
  assign bus.r_timeout          = timeout_q;
`else
  assign bus.r_timeout          = 1'b0;
`endif
  assign busy = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_match_sequencer.sv
// Self-checking bench for match_sequencer with a behavioural matcher and a
// result model: results in push order, cycles = matcher latency (saturated/watchdogged).
module tb_match_sequencer;
  localparam int AW = 4;
  localparam int QD = 4;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] cfg_s;
  logic [AW-1:0] cfg_e;
  logic          busy;

  match_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

  match_sequencer #(.ADDR_WIDTH(AW), .QDEPTH(QD), .TIMEOUT_CYCLES(TO)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .cfg_vocab_start_addr (cfg_s),
    .cfg_vocab_end_addr   (cfg_e),
    .busy                 (busy),
    .bus                  (bus)
  );

  always #5 clk = ~clk;

  int            n_cmp   = 0;
  int            n_err   = 0;
  int            res_cnt = 0;
  int            rr_mode = 0;  // 0: always ready, 1: random, 2: held off
  int            lat_tab [16];  // matcher latency per query address; 0 = never done
  bit            found_tab [16];
  logic [AW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void ref_result(input int a, output bit f, output int c, output bit t);
`ifdef MATCH_SEQ_TIMEOUT_EN
    if (lat_tab[a] == 0 || lat_tab[a] > TO) begin
      f = 1'b0; c = TO; t = 1'b1;
    end else begin
      f = found_tab[a]; c = lat_tab[a]; t = 1'b0;
    end
`else
    f = found_tab[a];
    c = (lat_tab[a] > 255) ? 255 : lat_tab[a];
    t = 1'b0;
`endif
  endfunction

  // behavioural matcher: done on the lat-th cycle of cs; noise on done/found otherwise
  int mk = 0;
  always @(negedge clk) begin
    if (rst || !bus.m_cs) begin
      mk          = 0;
      bus.m_done  = 1'($urandom_range(0, 1));
      bus.m_found = 1'($urandom_range(0, 1));
    end else begin
      mk++;
      bus.m_done  = (lat_tab[bus.m_input_start_addr] != 0) && (mk == lat_tab[bus.m_input_start_addr]);
      bus.m_found = bus.m_done ? found_tab[bus.m_input_start_addr] : 1'($urandom_range(0, 1));
    end
  end

  // result consumer, stability and release-gap checks
  logic          mcs_d1 = 1'b0, mcs_d2 = 1'b0, prev_valid = 1'b0;
  logic          prev_found, prev_to;
  logic [AW-1:0] prev_addr;
  logic [7:0]    prev_cyc;
  always @(negedge clk) begin
    bit f, t;
    int c;
    logic [AW-1:0] a;
    if (rst) begin
      bus.r_ready = 1'b0;
      mcs_d1 = 1'b0; mcs_d2 = 1'b0; prev_valid = 1'b0;
    end else begin
      if (bus.m_cs && exp_q.size() != 0) begin
        check("m_vocab_start", bus.m_vocab_start_addr, cfg_s);
        check("m_vocab_end", bus.m_vocab_end_addr, cfg_e);
        check("m_input_addr", bus.m_input_start_addr, exp_q[0]);
      end
      if (bus.r_valid) begin
        check("resp_mcs_low", bus.m_cs, 1'b0);
        if (!prev_valid) begin
          check("release_gap", {mcs_d2, mcs_d1}, 2'b10);
        end else begin
          check("hold_found", bus.r_found, prev_found);
          check("hold_addr", bus.r_addr, prev_addr);
          check("hold_cycles", bus.r_cycles, prev_cyc);
          check("hold_timeout", bus.r_timeout, prev_to);
        end
      end
      case (rr_mode)
        0:       bus.r_ready = 1'b1;
        1:       bus.r_ready = 1'($urandom_range(0, 1));
        default: bus.r_ready = 1'b0;
      endcase
      if (bus.r_valid && bus.r_ready) begin
        res_cnt++;
        check("result_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          a = exp_q.pop_front();
          ref_result(int'(a), f, c, t);
          check("r_addr", bus.r_addr, a);
          check("r_found", bus.r_found, f);
          check("r_cycles", bus.r_cycles, c);
          check("r_timeout", bus.r_timeout, t);
        end
      end
      prev_valid = bus.r_valid;
      prev_found = bus.r_found;
      prev_addr  = bus.r_addr;
      prev_cyc   = bus.r_cycles;
      prev_to    = bus.r_timeout;
      mcs_d2     = mcs_d1;
      mcs_d1     = bus.m_cs;
    end
  end

  // call at a negedge; returns one negedge after the accepting edge
  task automatic push(input logic [AW-1:0] a);
    int t = 0;
    bus.q_valid = 1'b1;
    bus.q_addr  = a;
    while (!bus.q_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("push_accept", bus.q_ready, 1'b1);
    if (bus.q_ready) exp_q.push_back(a);
    @(negedge clk);
    bus.q_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    check("drain_idle", busy, 1'b0);
  endtask

  initial begin
    int t;
    int acc;
    int saved;
    rst = 1'b1;
    bus.q_valid = 1'b0;
    bus.q_addr  = '0;
    cfg_s = 4'd2;
    cfg_e = 4'd11;
    for (int i = 0; i < 16; i++) begin
      lat_tab[i]   = 3;
      found_tab[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    check("rst_q_ready", bus.q_ready, 1'b1);
    check("rst_r_valid", bus.r_valid, 1'b0);
    check("rst_r_found", bus.r_found, 1'b0);
    check("rst_r_timeout", bus.r_timeout, 1'b0);
    check("rst_r_addr", bus.r_addr, 0);
    check("rst_r_cycles", bus.r_cycles, 0);
    check("rst_m_cs", bus.m_cs, 1'b0);
    check("rst_m_vs", bus.m_vocab_start_addr, 0);
    check("rst_m_ve", bus.m_vocab_end_addr, 0);
    check("rst_m_in", bus.m_input_start_addr, 0);
    check("rst_busy", busy, 1'b0);

    // single query: done with found on 5th search cycle
    lat_tab[0] = 5; found_tab[0] = 1'b1;
    push(4'd0);
    drain();
    check("single_res_cnt", res_cnt, 1);

    // FIFO fill: long searches, five back-to-back pushes then full
    for (int i = 1; i <= 6; i++) begin
      lat_tab[i] = 20; found_tab[i] = i[0];
    end
    acc = 0;
    for (int k = 1; k <= 5; k++) begin
      check("fill_ready", bus.q_ready, (acc - ((acc >= 2) ? 1 : 0)) < QD);
      bus.q_valid = 1'b1;
      bus.q_addr  = AW'(k);
      exp_q.push_back(AW'(k));
      acc++;
      @(negedge clk);
      check("fill_mcs", bus.m_cs, acc >= 2);
    end
    bus.q_addr = 4'd6;
    for (int k = 0; k < 3; k++) begin
      check("fill_full", bus.q_ready, 1'b0);
      check("fill_busy", busy, 1'b1);
      @(negedge clk);
    end
    t = 0;
    while (!bus.q_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("fill_ready_after_pop", bus.q_ready, 1'b1);
    check("fill_pop_launch", bus.m_cs, 1'b1);
    exp_q.push_back(4'd6);
    @(negedge clk);
    bus.q_valid = 1'b0;
    drain();
    check("fill_res_cnt", res_cnt, 7);

    // backpressure: hold r_ready low for 10 RESP cycles
    lat_tab[8] = 3; lat_tab[9] = 2; found_tab[8] = 1'b1; found_tab[9] = 1'b0;
    rr_mode = 2;
    push(4'd8);
    push(4'd9);
    t = 0;
    while (!bus.r_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("bp_r_valid", bus.r_valid, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_hold_valid", bus.r_valid, 1'b1);
      check("bp_no_launch", bus.m_cs, 1'b0);
    end
    rr_mode = 0;
    t = 0;
    while (bus.r_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("bp_released", bus.r_valid, 1'b0);
    check("bp_idle_gap", bus.m_cs, 1'b0);
    @(negedge clk);
    check("bp_next_launch", bus.m_cs, 1'b1);
    drain();

    // reset on the 3rd search cycle discards in-flight and queued queries
    lat_tab[10] = 0; lat_tab[11] = 4;
    push(4'd10);
    push(4'd11);
    t = 0;
    while (!bus.m_cs && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("mid_launch", bus.m_cs, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    check("mid_rst_mcs", bus.m_cs, 1'b0);
    check("mid_rst_rvalid", bus.r_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_qready", bus.q_ready, 1'b1);
    rst = 1'b0;
    saved = res_cnt;
    repeat (20) @(negedge clk);
    check("mid_no_result", res_cnt, saved);
    check("mid_idle", busy, 1'b0);

`ifdef MATCH_SEQ_TIMEOUT_EN
    lat_tab[12] = 0; found_tab[12] = 1'b1;
    push(4'd12);
    drain();
    lat_tab[13] = TO; found_tab[13] = 1'b1;
    push(4'd13);
    drain();
`else
    lat_tab[14] = 300; found_tab[14] = 1'b1;
    push(4'd14);
    drain();
`endif

    // randomized traffic with random gaps, latencies and consumer stalls
    for (int i = 0; i < 16; i++) begin
      lat_tab[i]   = $urandom_range(1, 12);
      found_tab[i] = 1'($urandom_range(0, 1));
    end
    cfg_s = 4'($urandom_range(0, 15));
    cfg_e = 4'($urandom_range(0, 15));
    rr_mode = 1;
    saved = res_cnt;
    for (int i = 0; i < 25; i++) begin
      push(4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    check("rand_res_cnt", res_cnt - saved, 25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
